// File: rtl/cla_pkg.sv
// Shared definitions for the CLA datapath family.
// Default group width, FSM state type and index-width helper.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int idx_w(input int width, input int gw);
    int ng;
    ng = width / gw;
    return (ng <= 1) ? 1 : $clog2(ng);
  endfunction

endpackage

// File: rtl/cla_sub_seq_if.sv
// Handshake bundle for cla_sub_seq: operands in, result and flags out.
// master drives in_valid/a/b/out_ready; slave drives the rest (ovf with CLA_SUB_OVF_EN).
interface cla_sub_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
`ifdef CLA_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  diff, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output diff, borrow, zero, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  diff, borrow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output diff, borrow, zero
  );
`endif

endinterface

// File: rtl/cla_group_unit.sv
// Combinational GW-bit carry-lookahead group: x + y + cin.
// Ports: x, y, cin in; sum, cout, c_msb_in (carry into top bit) out.
module cla_group_unit #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] x,
  input  logic [GW-1:0] y,
  input  logic          cin,
  output logic [GW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  logic [GW-1:0] p;
  logic [GW-1:0] g;
  logic [GW:0]   c;
  logic          t;

  assign p = x ^ y;
  assign g = x & y;

  // Each carry is the flattened sum-of-products, not a ripple chain.
  always_comb begin
    c    = '0;
    t    = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= GW; i++) begin
      t = cin;
      for (int k = 0; k < i; k++)
        t = t & p[k];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++)
          t = t & p[k];
        c[i] = c[i] | t;
      end
    end
  end

  assign sum      = p ^ c[GW-1:0];
  assign cout     = c[GW];
  assign c_msb_in = c[GW-1];

endmodule

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: diff = a + ~b + 1, one lookahead group per cycle.
// Ports: clk, rst_n, bus (slave): handshakes, a, b, diff, borrow, zero, ovf with CLA_SUB_OVF_EN.
module cla_sub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = cla_pkg::GROUP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  cla_sub_seq_if.slave bus
);

  localparam int NG = WIDTH / GROUP_W;
  localparam int IW = idx_w(WIDTH, GROUP_W);

  if (WIDTH % GROUP_W != 0) begin : g_bad_width
    $error("cla_sub_seq: WIDTH must be a multiple of GROUP_W");
  end

  state_t state;
  state_t state_nx;

  logic [IW-1:0]      idx;
  logic               carry;
  logic [WIDTH-1:0]   ar;
  logic [WIDTH-1:0]   br;
  logic [WIDTH-1:0]   diffr;
  logic               borrowr;
  logic               zeror;
  logic [GROUP_W-1:0] xs;
  logic [GROUP_W-1:0] ys;
  logic [GROUP_W-1:0] sum;
  logic               cout;
  logic               cmsb;
  logic [WIDTH-1:0]   diff_nx;
  logic               last;
  logic               acc;
  logic               rel;

  assign xs   = GROUP_W'(ar >> (idx * GROUP_W));
  assign ys   = GROUP_W'(br >> (idx * GROUP_W));
  assign last = (idx == IW'(NG - 1));
  assign acc  = bus.in_valid && bus.in_ready;
  assign rel  = bus.out_valid && bus.out_ready;

  // diffr is cleared on accept, so OR-ing in the slice is a write.
  assign diff_nx = diffr | (WIDTH'(sum) << (idx * GROUP_W));

  cla_group_unit #(
    .GW(GROUP_W)
  ) u_grp (
    .x       (xs),
    .y       (ys),
    .cin     (carry),
    .sum     (sum),
    .cout    (cout),
    .c_msb_in(cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc)  state_nx = CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (rel)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): bus.in_ready  = 1'b1;
      (state == DONE): bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      ar      <= '0;
      br      <= '0;
      diffr   <= '0;
      borrowr <= 1'b0;
      zeror   <= 1'b0;
    end else if (state == IDLE && acc) begin
      ar    <= bus.a;
      br    <= ~bus.b;
      carry <= 1'b1;
      idx   <= '0;
      diffr <= '0;
    end else if (state == CALC) begin
      diffr <= diff_nx;
      carry <= cout;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        borrowr <= ~cout;
        zeror   <= (diff_nx == '0);
      end
    end
  end

  assign bus.diff   = diffr;
  assign bus.borrow = borrowr;
  assign bus.zero   = zeror;

`ifdef CLA_SUB_OVF_EN
  logic ovfr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovfr <= 1'b0;
    else if (state == CALC && last)
      ovfr <= cmsb ^ cout;
  end

  assign bus.ovf = ovfr;
`endif

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed and back-to-back checks for cla_sub_seq (WIDTH 16, GROUP_W 4).
// Build with CLA_SUB_OVF_EN defined to cover the ovf port as well.
module tb_cla_sub_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  cla_sub_seq_if #(.WIDTH(16)) bus ();

  cla_sub_seq #(
    .WIDTH  (16),
    .GROUP_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick;
      n++;
    end
    chk(tag, n, 4);
  endtask

  task automatic start(input logic [15:0] a,
                       input logic [15:0] b);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] ed,
                     input logic eb,
                     input logic ez);
    start(a, b);
    wait_out({tag, " lat"});
    chk({tag, " diff"}, bus.diff, ed);
    chk({tag, " borrow"}, bus.borrow, eb);
    chk({tag, " zero"}, bus.zero, ez);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk({tag, " ov_clr"}, bus.out_valid, 0);
    chk({tag, " rdy"}, bus.in_ready, 1);
  endtask

  logic [15:0] ra;
  logic [15:0] rb;
  logic [31:0] q[$];
  logic [31:0] ent;
  logic [15:0] ed;
  int          got;
  int          cyc;
  logic        fi;

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #23;
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst diff", bus.diff, 0);
    chk("rst borrow", bus.borrow, 0);
    chk("rst zero", bus.zero, 0);
`ifdef CLA_SUB_OVF_EN
    chk("rst ovf", bus.ovf, 0);
`endif
    rst_n = 1'b1;
    tick;

    run("t1", 16'h1234, 16'h0234, 16'h1000, 0, 0);
    run("t2", 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    run("t3", 16'h5A5A, 16'h5A5A, 16'h0000, 0, 1);
    run("t4", 16'h8000, 16'h0001, 16'h7FFF, 0, 0);
`ifdef CLA_SUB_OVF_EN
    chk("t4 ovf", bus.ovf, 1);
`endif
    run("t5", 16'h0005, 16'h0003, 16'h0002, 0, 0);
`ifdef CLA_SUB_OVF_EN
    chk("t5 ovf", bus.ovf, 0);
`endif

    start(16'h0100, 16'h0001);
    wait_out("bp lat");
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      bus.a        = 16'hFFFF;
      bus.b        = 16'h0000;
      tick;
      chk("bp diff", bus.diff, 16'h00FF);
      chk("bp borrow", bus.borrow, 0);
      chk("bp in_ready", bus.in_ready, 0);
      chk("bp out_valid", bus.out_valid, 1);
    end
    bus.a         = 16'h0003;
    bus.b         = 16'h0007;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("bp rel rdy", bus.in_ready, 1);
    chk("bp rel ov", bus.out_valid, 0);
    tick;
    bus.in_valid = 1'b0;
    wait_out("bp2 lat");
    chk("bp2 diff", bus.diff, 16'hFFFC);
    chk("bp2 borrow", bus.borrow, 1);
    chk("bp2 zero", bus.zero, 0);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;

    start(16'h1234, 16'h0001);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("mrst out_valid", bus.out_valid, 0);
    chk("mrst diff", bus.diff, 0);
    chk("mrst in_ready", bus.in_ready, 1);
    #2;
    rst_n = 1'b1;
    tick;
    run("post", 16'h00FF, 16'h0001, 16'h00FE, 0, 0);

    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'($urandom);
    bus.b         = 16'($urandom);
    got           = 0;
    cyc           = 0;
    while (got < 200 && cyc < 3000) begin
      fi = bus.in_ready;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("b2b queue", 0, 1);
        end else begin
          ent = q.pop_front();
          ra  = ent[31:16];
          rb  = ent[15:0];
          ed  = ra - rb;
          chk("b2b diff", bus.diff, ed);
          chk("b2b borrow", bus.borrow, ra < rb);
          chk("b2b zero", bus.zero, ed == 0);
        end
        got++;
      end
      if (fi) q.push_back({bus.a, bus.b});
      tick;
      cyc++;
      if (fi) begin
        bus.a = 16'($urandom);
        bus.b = (cyc % 17 == 0) ? bus.a
                                : 16'($urandom);
      end
    end
    chk("b2b count", got, 200);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
